// File: rtl/seg7_axis_display.sv
// Valid/ready sink that holds each frame of seven-segment patterns for a minimum
// time while multiplexing it onto a common-anode display. Define SEG7_ACTIVE_LOW_EN for inverted segments.
module seg7_axis_display #(
    parameter int DIGITS      = 2,
    parameter int DWELL       = 100000,
    parameter int HOLD_FRAMES = 50
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [DIGITS-1:0][6:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [6:0]             seg,
    output logic [DIGITS-1:0]      an
);

    localparam int unsigned HOLD_T  = HOLD_FRAMES * DIGITS * DWELL;
    localparam int unsigned HOLD_W  = (HOLD_T > 2) ? $clog2(HOLD_T - 1) : 1;
    localparam int unsigned DWELL_W = $clog2(DWELL);
    localparam int unsigned DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef SEG7_ACTIVE_LOW_EN
    localparam logic [6:0] SEG_OFF = 7'h7F;
`else
    localparam logic [6:0] SEG_OFF = 7'h00;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        READY
    } state_t;

    state_t                   state_q, state_d;
    logic [DIGITS-1:0][6:0]   frame_q, frame_d;
    logic [DWELL_W-1:0]       dwell_q, dwell_d;
    logic [DIG_W-1:0]         digit_q, digit_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;
    logic                     s_ready_q, s_ready_d;
    logic [6:0]               seg_q, seg_d;
    logic [DIGITS-1:0]        an_q, an_d;
    logic                     accept;

    assign accept  = s_valid && s_ready_q;
    assign s_ready = s_ready_q;
    assign seg     = seg_q;
    assign an      = an_q;

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        dwell_d = dwell_q;
        digit_d = digit_q;
        hold_d  = hold_q;

        if (accept) begin
            frame_d = s_data;
            dwell_d = '0;
            digit_d = '0;
            hold_d  = '0;
            state_d = SHOW;
        end else if (state_q != IDLE) begin
            if (dwell_q == DWELL_W'(DWELL - 1)) begin
                dwell_d = '0;
                digit_d = (digit_q == DIG_W'(DIGITS - 1)) ? '0 : digit_q + DIG_W'(1);
            end else begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
            // Leaving SHOW at T-2 lets the registered s_ready rise exactly T-1 edges after accept.
            if (state_q == SHOW) begin
                if (hold_q == HOLD_W'(HOLD_T - 2)) begin
                    state_d = READY;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
        end

        s_ready_d = (state_d != SHOW);

        // Outputs come from next-state values so anode and segments switch on the same edge.
        if (state_d == IDLE) begin
            an_d  = '1;
            seg_d = SEG_OFF;
        end else begin
            an_d  = ~(DIGITS'(1) << digit_d);
`ifdef SEG7_ACTIVE_LOW_EN
            seg_d = ~frame_d[digit_d];
`else
            seg_d = frame_d[digit_d];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            dwell_q   <= '0;
            digit_q   <= '0;
            hold_q    <= '0;
            s_ready_q <= 1'b0;
            seg_q     <= SEG_OFF;
            an_q      <= '1;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            dwell_q   <= dwell_d;
            digit_q   <= digit_d;
            hold_q    <= hold_d;
            s_ready_q <= s_ready_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

endmodule
